// File: rtl/spi_slave_if.sv
// spi_slave_if: 4-wire SPI slave front end for the single-port RAM.
// Deserialises 10-bit MOSI frames {cmd[1:0], byte[7:0]} onto rx_data with a
// one-cycle rx_valid strobe. It serialises the 8-bit RAM read response back
// out on MISO, MSB first.
// Optional feature macro: SPI_SLAVE_RD_ORDER_EN (read-order guard). When it is
// defined, a read-data frame is only accepted after a read-address frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for SS_n low; MISO held at 0
// CHK_CMD   | sampling d9 to choose the write or read branch
// WRITE     | write-address / write-data frame (d9 = 0)
// READ_ADD  | read-address frame (also the common read path without guard)
// READ_DATA | read-data frame: receive, wait for tx_valid, shift out MISO
//
// Inside the three frame states, a sub-phase tracks the frame's progress:
// receive bits, wait for RAM data, transmit, done (ignore MOSI until SS_n high).

module spi_slave_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

`ifdef SPI_SLAVE_RD_ORDER_EN
  localparam bit RD_ORDER_EN = 1'b1;
`else
  localparam bit RD_ORDER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_RX   = 2'd0,
    PH_WAIT = 2'd1,
    PH_TX   = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  state_t     state, state_nxt;
  phase_t     phase, phase_nxt;

  logic [3:0] bit_cnt;       // down-counter shared by the receive and transmit phases
  logic [8:0] rx_shift;
  logic [7:0] tx_shift;
  logic       rd_addr_seen;

  logic       abort;
  logic       cmd_shift;
  logic       data_shift;
  logic       rx_last;
  logic       tx_load;
  logic       tx_shift_en;
  logic       tx_end;
  logic [9:0] rx_word;

  // State and phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= PH_RX;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    abort       = 1'b0;
    cmd_shift   = 1'b0;
    data_shift  = 1'b0;
    rx_last     = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_end      = 1'b0;
    rx_word     = {rx_shift, MOSI};

    if (state != IDLE && SS_n) begin
      abort     = 1'b1;
      state_nxt = IDLE;
      phase_nxt = PH_RX;
    end else begin
      case (state)
        IDLE: begin
          if (!SS_n) begin
            state_nxt = CHK_CMD;
            phase_nxt = PH_RX;
          end
        end
        CHK_CMD: begin
          cmd_shift = 1'b1;
          if (!MOSI)
            state_nxt = WRITE;
          else if (RD_ORDER_EN && rd_addr_seen)
            state_nxt = READ_DATA;
          else
            state_nxt = READ_ADD;
        end
        default: begin
          case (phase)
            PH_RX: begin
              if (bit_cnt == 4'd0) begin
                rx_last   = 1'b1;
                phase_nxt = (state == READ_DATA) ? PH_WAIT : PH_DONE;
              end else begin
                data_shift = 1'b1;
              end
              // Without the guard, d8 (the first bit here) picks the read flavour.
              if (!RD_ORDER_EN && state == READ_ADD && bit_cnt == 4'd8 && MOSI)
                state_nxt = READ_DATA;
            end
            PH_WAIT: begin
              if (tx_valid) begin
                tx_load   = 1'b1;
                phase_nxt = PH_TX;
              end
            end
            PH_TX: begin
              tx_shift_en = 1'b1;
              if (bit_cnt == 4'd0) begin
                tx_end    = 1'b1;
                phase_nxt = PH_DONE;
              end
            end
            default: begin
              phase_nxt = PH_DONE;
            end
          endcase
        end
      endcase
    end

    // The guard makes the command bit follow the branch actually taken.
    if (RD_ORDER_EN) begin
      if (state == READ_DATA)
        rx_word[8] = 1'b1;
      else if (state == READ_ADD)
        rx_word[8] = 1'b0;
    end
  end

  // Shift registers, bit counter, outputs and the read-order flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= 4'd0;
      rx_shift     <= 9'd0;
      tx_shift     <= 8'd0;
      rx_data      <= 10'd0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= rx_last;
      MISO     <= tx_shift_en ? tx_shift[7] : 1'b0;

      if (rx_last)
        rx_data <= rx_word;

      if (abort)
        rx_shift <= 9'd0;
      else if (cmd_shift || data_shift)
        rx_shift <= {rx_shift[7:0], MOSI};

      if (abort)
        bit_cnt <= 4'd0;
      else if (cmd_shift)
        bit_cnt <= 4'd8;
      else if (tx_load)
        bit_cnt <= 4'd7;
      else if ((data_shift || tx_shift_en) && bit_cnt != 4'd0)
        bit_cnt <= bit_cnt - 4'd1;

      if (abort)
        tx_shift <= 8'd0;
      else if (tx_load)
        tx_shift <= tx_data;
      else if (tx_shift_en)
        tx_shift <= {tx_shift[6:0], 1'b0};

      if (rx_last && state == READ_ADD)
        rd_addr_seen <= 1'b1;
      else if (tx_end)
        rd_addr_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: drives SPI frames with randomised payloads,
// timing and RAM latency. It checks every cycle against a frame-level model
// of the command decode, the attached RAM and the MISO response schedule.

module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;

  // Model state: RAM contents and address registers, the read-order flag, held rx_data.
  logic [7:0] mem [256];
  logic [7:0] wr_addr_m;
  logic [7:0] rd_addr_m;
  logic       seen_m;
  logic [9:0] rx_m;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // ss_req: >0 explicit number of SS_n-low edges, -1 complete frame, -2 truncated transmit.
  // rst_off: >=0 asserts rst at edge (capture edge + rst_off).
  task automatic send_frame(input logic [9:0] word, input int ss_req, input int lat,
                            input int gap, input int rst_off);
    logic [9:0] rx_new;
    logic [7:0] resp;
    logic       is_tx, full, exp_v, exp_miso;
    logic [9:0] exp_rx;
    int         cap, ss_len, ncyc, rst_at, j;

    rx_new = word;
`ifdef SPI_SLAVE_RD_ORDER_EN
    if (word[9]) rx_new[8] = seen_m;
`endif
    is_tx = (rx_new[9:8] == 2'b11);
    resp  = mem[rd_addr_m];
    cap   = 11 + lat;
    if (ss_req > 0)
      ss_len = ss_req;
    else if (ss_req == -2 && is_tx)
      ss_len = cap + 1 + $urandom_range(0, 5);
    else if (is_tx)
      ss_len = cap + 10 + $urandom_range(0, 2);
    else
      ss_len = 11 + $urandom_range(0, 3);
    full   = (ss_len >= 11);
    rst_at = (rst_off >= 0) ? cap + rst_off : -1;
    ncyc   = ss_len + gap;

    @(negedge clk);
    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = ($urandom_range(0, 3) == 0);
    tx_data  = 8'($urandom);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        checks++;
        if (MISO !== 1'b0) begin failures++; $display("FAIL rst_miso got=%b exp=0", MISO); end
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        checks++;
        if (rx_data !== 10'd0) begin failures++; $display("FAIL rst_rx_data got=%h exp=000", rx_data); end
        rst      = 1'b0;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        rx_m     = 10'd0;
        seen_m   = 1'b0;
        return;
      end
      exp_v    = full && (k == 10);
      exp_rx   = (full && k >= 10) ? rx_new : rx_m;
      exp_miso = 1'b0;
      if (is_tx && k >= cap + 1 && k <= cap + 8 && k <= ss_len - 1)
        exp_miso = resp[7 - (k - cap - 1)];
      checks++;
      if (rx_valid !== exp_v) begin
        failures++;
        $display("FAIL rx_valid word=%h k=%0d got=%b exp=%b", word, k, rx_valid, exp_v);
      end
      checks++;
      if (rx_data !== exp_rx) begin
        failures++;
        $display("FAIL rx_data word=%h k=%0d got=%h exp=%h", word, k, rx_data, exp_rx);
      end
      checks++;
      if (MISO !== exp_miso) begin
        failures++;
        $display("FAIL miso word=%h k=%0d got=%b exp=%b", word, k, MISO, exp_miso);
      end
      if (full && k == 10) begin
        rx_m = rx_new;
        case (rx_new[9:8])
          2'b00: wr_addr_m = rx_new[7:0];
          2'b01: mem[wr_addr_m] = rx_new[7:0];
          2'b10: begin rd_addr_m = rx_new[7:0]; seen_m = 1'b1; end
          default: ;
        endcase
      end
      j        = k + 1;
      SS_n     = !(j <= ss_len - 1);
      MOSI     = (j >= 1 && j <= 10) ? word[10 - j] : 1'($urandom);
      rst      = (j == rst_at);
      if (is_tx && full && j >= 11 && j <= cap)
        tx_valid = (j == cap);
      else
        tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = (is_tx && j == cap) ? resp : 8'($urandom);
    end
    if (is_tx && full && ss_len - 1 >= cap + 8)
      seen_m = 1'b0;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst  = 1'b1;
    SS_n = 1'($urandom);
    MOSI = 1'($urandom);
    repeat (2) @(negedge clk);
    checks++;
    if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++;
    if (rx_data !== 10'd0) begin failures++; $display("FAIL reset_rx_data got=%h exp=000", rx_data); end
    rst    = 1'b0;
    SS_n   = 1'b1;
    rx_m   = 10'd0;
    seen_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_addr();
    send_frame(10'h03A, -1, 1, 1, -1);
    checks++;
    if (rx_data !== 10'h03A) begin failures++; $display("FAIL write_addr got=%h exp=03a", rx_data); end
  endtask

  task automatic test_write_read_back();
    send_frame(10'h03A, -1, 1, 1, -1);
    send_frame(10'h1C5, -1, 1, 1, -1);
    send_frame(10'h23A, -1, 1, 1, -1);
    checks++;
    if (mem[8'h3A] !== 8'hC5) begin failures++; $display("FAIL ram_model got=%h exp=c5", mem[8'h3A]); end
    send_frame(10'h300 | 10'($urandom_range(0, 255)), -1, 1, 1, -1);
  endtask

  task automatic test_abort();
    send_frame(10'($urandom), 6, 1, 1, -1);
    send_frame(10'h207, -1, 1, 1, -1);
    checks++;
    if (rx_data !== 10'h207) begin failures++; $display("FAIL abort_next got=%h exp=207", rx_data); end
  endtask

  task automatic test_config();
    test_reset();
    send_frame(10'h055, -1, 1, 1, -1);
    send_frame(10'h1A7, -1, 1, 1, -1);
    send_frame(10'h355, -1, 2, 1, -1);
`ifdef SPI_SLAVE_RD_ORDER_EN
    checks++;
    if (rx_data !== 10'h255) begin failures++; $display("FAIL guard_first got=%h exp=255", rx_data); end
    send_frame(10'h200, -1, 1, 1, -1);
    checks++;
    if (rx_data !== 10'h300) begin failures++; $display("FAIL guard_second got=%h exp=300", rx_data); end
`else
    checks++;
    if (rx_data !== 10'h355) begin failures++; $display("FAIL noguard_first got=%h exp=355", rx_data); end
`endif
  endtask

  task automatic test_truncated_tx();
    send_frame(10'h211, -1, 1, 1, -1);
    send_frame(10'h3FF, -2, 1, 2, -1);
    send_frame(10'h3FF, -2, 3, 1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      send_frame(10'($urandom_range(0, 511)), -1, 1, 0, -1);
  endtask

  task automatic test_reset_mid_tx();
    send_frame(10'h23A, -1, 1, 1, -1);
    send_frame(10'h300, -1, 1, 1, 4);
    send_frame(10'h012, -1, 1, 1, -1);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        send_frame(10'($urandom), -1, $urandom_range(1, 3), $urandom_range(0, 2), -1);
      else if (r < 8)
        send_frame(10'($urandom), $urandom_range(1, 10), 1, $urandom_range(0, 2), -1);
      else
        send_frame(10'($urandom), -2, $urandom_range(1, 3), $urandom_range(1, 2), -1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    wr_addr_m = 8'd0;
    rd_addr_m = 8'd0;
    seen_m    = 1'b0;
    rx_m      = 10'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    test_reset();
    test_write_addr();
    test_write_read_back();
    test_abort();
    test_config();
    test_truncated_tx();
    test_back_to_back();
    test_reset_mid_tx();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end for the single-port RAM: a 4-wire SPI slave that deserialises MOSI frames into 10-bit command words on `rx_data` with an `rx_valid` strobe, and serialises the 8-bit RAM read response (`tx_data`/`tx_valid`) back out on MISO. It sits between the chip pins and the RAM command port. It is the initiator side of the RAM's `{cmd[1:0], byte[7:0]}` interface: 00 write-address, 01 write-data, 10 read-address, 11 read-data.

## Interface
- (no parameters; frame length fixed at 10 bits, response at 8 bits)
- `clk`  in  1  system clock; MOSI/SS_n sampled and MISO driven on rising edge
- `rst`  in  1  synchronous, active-high reset
- `SS_n`  in  1  slave select, active low; high aborts/ends a frame
- `MOSI`  in  1  serial data in, MSB first
- `MISO`  out  1  serial data out, MSB first; 0 when not transmitting
- `rx_data`  out  10  assembled command word `{cmd[1:0], byte[7:0]}`; held between frames
- `rx_valid`  out  1  one-cycle strobe, `rx_data` complete
- `tx_data`  in  8  RAM read data
- `tx_valid`  in  1  RAM read data valid

## Operation
- Reset: state IDLE; `MISO`=0, `rx_valid`=0, `rx_data`=0, bit counter=0, `rd_addr_seen`=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n sampled low -> CHK_CMD. No data captured in this cycle.
- CHK_CMD: MOSI sampled as d9, shifted in. d9=0 -> WRITE; d9=1 -> READ_ADD or READ_DATA (see Configuration).
- WRITE / READ_ADD / READ_DATA: d8..d0 shifted in over the next 9 cycles. The cycle after d0 is sampled, `rx_valid`=1 for exactly one cycle and `rx_data`={d9..d0}.
- WRITE, READ_ADD: after the strobe, MOSI is ignored until SS_n high. READ_ADD strobe sets `rd_addr_seen`.
- READ_DATA: after the strobe, wait for `tx_valid`=1 and capture `tx_data` into the tx shift register. On the next 8 cycles MISO = tx_data[7], …, tx_data[0]. Then MISO=0 and `rd_addr_seen` is cleared. `tx_valid` outside this wait window is ignored.
- SS_n high in any non-IDLE state -> IDLE next cycle. Counter and tx shift register are cleared and MISO=0. No `rx_valid` for an incomplete frame. `rd_addr_seen` is unchanged.
- `rst` overrides everything, including mid-frame and mid-transmit.

## Timing
- SS_n falls (sampled at edge E0) -> d9 sampled at E1 -> d0 sampled at E10 -> `rx_valid` high during cycle after E10. Frame latency: 11 cycles from first SS_n-low sample.
- RAM returns `tx_valid` one cycle after the `rx_valid` cycle. The capture edge is the edge where `tx_valid` is sampled high. MISO carries bit 7 from the following edge for 8 cycles.
- A full read-data transaction needs SS_n low for ≥ 20 cycles. Deasserting earlier truncates MISO.
- Back-to-back frames need SS_n high for ≥ 1 sampled cycle.

## Configuration
- `SPI_SLAVE_RD_ORDER_EN` defined: read-order guard.
  - In CHK_CMD with d9=1, the branch is READ_DATA if `rd_addr_seen`=1, else READ_ADD.
  - `rx_data[8]` is forced to 1 in READ_DATA and to 0 in READ_ADD, regardless of the received d8.
  - A read-data frame can therefore never precede a read-address frame.
- Not defined: no guard.
  - d9=1 moves to a common read path. Once d8 is sampled, d8=0 -> READ_ADD and d8=1 -> READ_DATA.
  - `rx_data` is passed verbatim. `rd_addr_seen` is still maintained but unused.

## Test plan
- Write address: frame 00_0x3A -> single `rx_valid` pulse 11 cycles after SS_n low, `rx_data`=0x03A, MISO stays 0.
- Write data then read back: frames 00_0x3A, 01_0xC5, 10_0x3A, 11_xx (RAM model attached) -> MISO shifts 1,1,0,0,0,1,0,1 over 8 cycles starting the edge after `tx_valid`.
- Abort: SS_n high after 5 bits of a frame -> no `rx_valid`, state IDLE next cycle, next full frame 10_0x07 decodes as `rx_data`=0x207.
- Guard (macro on): read frame 11_0x55 sent with `rd_addr_seen`=0 -> `rx_data`=0x255 and no MISO activity. A second read frame 10_0x00 -> `rx_data`=0x300, and the RAM byte appears on MISO.
- No guard (macro off): same first frame 11_0x55 -> `rx_data`=0x355 and a transmit on `tx_valid`.
- Reset mid-transmit: assert `rst` after 3 MISO bits -> MISO=0, `rx_valid`=0, `rx_data`=0, and IDLE on the next edge.
